// File: rtl/clock_divider_multi_pkg.sv
// Shared constants for the multi-channel clock divider.
// Divisors below MIN_DIV are raised to MIN_DIV so a channel always has a low and a high slot.
package clock_divider_multi_pkg;

    localparam int CNT_W_DEF   = 27;
    localparam int DEF_DIV_DEF = 500;
    localparam int MIN_DIV     = 2;

    function automatic int clamp_div_int(input int d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/clock_divider_chan.sv
// One divider channel: registered clk_out, tick and load_ack one clk_in edge after the deciding count.
// No backpressure: load is a fire-and-forget strobe and the latest shadow values win.
module clock_divider_chan
    import clock_divider_multi_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             ch_en,
    input  logic [CNT_W-1:0] div_val,
    input  logic [CNT_W-1:0] hi_cnt,
    input  logic             load,
    output logic             load_ack,
    output logic             clk_out,
    output logic             rise_tick,
    output logic             fall_tick
);

    localparam logic [CNT_W-1:0] RST_DIV   = CNT_W'(clamp_div_int(DEF_DIV));
    localparam logic [CNT_W-1:0] RST_HI    = CNT_W'(DEF_DIV / 2);
    localparam logic [CNT_W-1:0] MIN_DIV_W = CNT_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_div_q, act_div_d;
    logic [CNT_W-1:0] act_hi_q, act_hi_d;
    logic [CNT_W-1:0] sh_div_q, sh_div_d;
    logic [CNT_W-1:0] sh_hi_q, sh_hi_d;
    logic             pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             ack_q, ack_d;

    logic             wrap;
    logic             apply;
    logic             high_phase;

    always_comb begin
        sh_div_d  = sh_div_q;
        sh_hi_d   = sh_hi_q;
        pend_d    = pend_q;
        act_div_d = act_div_q;
        act_hi_d  = act_hi_q;
        ack_d     = 1'b0;
        cnt_d     = cnt_q;

        if (load) begin
            sh_div_d = (div_val < MIN_DIV_W) ? MIN_DIV_W : div_val;
            sh_hi_d  = hi_cnt;
            pend_d   = 1'b1;
        end

        // A load landing on the wrap cycle (or while idle) is applied in that same cycle.
        wrap  = (cnt_q == act_div_q - ONE);
        apply = pend_d && (!ch_en || wrap);

        if (apply) begin
            act_div_d = sh_div_d;
            act_hi_d  = sh_hi_d;
            pend_d    = 1'b0;
            ack_d     = 1'b1;
        end

        if (!ch_en || apply || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        // clk_out tracks the count it is registered alongside, so it is always f(cnt_q).
        high_phase = (act_hi_d >= act_div_d) || (cnt_d >= act_div_d - act_hi_d);
        clk_out_d  = ch_en && high_phase;
        rise_d     = clk_out_d && !clk_out_q;
        fall_d     = !clk_out_d && clk_out_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q     <= '0;
            act_div_q <= RST_DIV;
            act_hi_q  <= RST_HI;
            sh_div_q  <= RST_DIV;
            sh_hi_q   <= RST_HI;
            pend_q    <= 1'b0;
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            act_div_q <= act_div_d;
            act_hi_q  <= act_hi_d;
            sh_div_q  <= sh_div_d;
            sh_hi_q   <= sh_hi_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            ack_q     <= ack_d;
        end
    end

    assign load_ack  = ack_q;
    assign clk_out   = clk_out_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent divider channels sharing clk_in; outputs registered, one edge after the deciding count.
// No backpressure: per-channel load strobes are always accepted.
module clock_divider_multi
    import clock_divider_multi_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    input  logic [NUM_CH*CNT_W-1:0] hi_cnt,
    input  logic [NUM_CH-1:0]       load,
    output logic [NUM_CH-1:0]       load_ack,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       rise_tick,
    output logic [NUM_CH-1:0]       fall_tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_divider_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_in    (clk_in),
            .rst       (rst),
            .ch_en     (ch_en[i]),
            .div_val   (div_val[i*CNT_W +: CNT_W]),
            .hi_cnt    (hi_cnt[i*CNT_W +: CNT_W]),
            .load      (load[i]),
            .load_ack  (load_ack[i]),
            .clk_out   (clk_out[i]),
            .rise_tick (rise_tick[i]),
            .fall_tick (fall_tick[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: vector table for divisor/duty shapes plus hand sequences
// for load timing, enable drop and reset abort.
module tb_clock_divider_multi;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 27;
    localparam int DEF_DIV = 500;
    localparam int LIMIT   = 3000;

    logic                    clk_in = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*CNT_W-1:0] div_val;
    logic [NUM_CH*CNT_W-1:0] hi_cnt;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH-1:0]       load_ack;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       rise_tick;
    logic [NUM_CH-1:0]       fall_tick;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    clock_divider_multi #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .ch_en     (ch_en),
        .div_val   (div_val),
        .hi_cnt    (hi_cnt),
        .load      (load),
        .load_ack  (load_ack),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // mode: 0 = toggling, 1 = stuck low, 2 = stuck high
    typedef struct {
        int ch;
        int div;
        int hi;
        int mode;
        int exp_lo;
        int exp_hi;
    } vec_t;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_cfg(input int ch, input int div, input int hi);
        div_val[ch*CNT_W +: CNT_W] = CNT_W'(div);
        hi_cnt[ch*CNT_W +: CNT_W]  = CNT_W'(hi);
    endtask

    task automatic pulse_load(input int ch);
        load[ch] = 1'b1;
        tick();
        load[ch] = 1'b0;
    endtask

    task automatic wait_edge(input int ch, input bit want_rise, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(want_rise ? rise_tick[ch] : fall_tick[ch]) && n < LIMIT);
    endtask

    // Returns high and low phase lengths (in clk_in cycles) of the next full period; -1 on timeout.
    task automatic measure(input int ch, output int lo, output int hi);
        int t;
        lo = -1;
        hi = -1;
        t  = 0;
        while (!rise_tick[ch] && t < LIMIT) begin
            tick();
            t++;
        end
        if (rise_tick[ch]) begin
            hi = 0;
            while (!fall_tick[ch] && hi < LIMIT) begin
                hi++;
                tick();
            end
            lo = 0;
            while (!rise_tick[ch] && lo < LIMIT) begin
                lo++;
                tick();
            end
        end
    endtask

    initial begin
        vec_t tbl[8];
        int   n, lo, hi, acks, other_acks, nticks, nbad;

        tbl[0] = '{0, 10,  3, 0, 7, 3};
        tbl[1] = '{0,  1,  1, 0, 1, 1};
        tbl[2] = '{1,  5,  2, 0, 3, 2};
        tbl[3] = '{0, 10,  0, 1, 0, 0};
        tbl[4] = '{1, 10, 12, 2, 0, 0};
        tbl[5] = '{1,  2,  1, 0, 1, 1};
        tbl[6] = '{0,  7,  7, 2, 0, 0};
        tbl[7] = '{1,  9,  8, 0, 1, 8};

        rst     = 1'b1;
        ch_en   = '0;
        load    = '0;
        div_val = '0;
        hi_cnt  = '0;
        repeat (3) tick();
        check("reset clk_out", clk_out, 0);
        check("reset rise_tick", rise_tick, 0);
        check("reset fall_tick", fall_tick, 0);
        check("reset load_ack", load_ack, 0);

        // Default divisor straight out of reset.
        ch_en = '1;
        rst   = 1'b0;
        wait_edge(0, 1'b1, n);
        check("default first rise", n, 250);
        measure(0, lo, hi);
        check("default high", hi, 250);
        check("default low", lo, 250);

        // Mid-period load: now at cnt=250, old period must finish before apply.
        set_cfg(0, 10, 3);
        pulse_load(0);
        n = 0;
        while (!load_ack[0] && n < 1000) begin
            tick();
            n++;
        end
        check("mid-period ack delay", n, 249);
        check("fall at apply", fall_tick[0], 1);
        tick();
        check("single ack", load_ack[0], 0);
        measure(0, lo, hi);
        check("div10 low", lo, 7);
        check("div10 high", hi, 3);

        // Enable drop while high, then re-enable.
        check("high before drop", clk_out[0], 1);
        ch_en[0] = 1'b0;
        tick();
        check("drop clk_out", clk_out[0], 0);
        check("drop fall_tick", fall_tick[0], 1);
        tick();
        check("drop single fall", fall_tick[0], 0);
        ch_en[0] = 1'b1;
        wait_edge(0, 1'b1, n);
        check("re-enable rise", n, 7);

        // At rise cnt=7; two ticks later the next edge is the wrap edge.
        tick();
        tick();
        set_cfg(0, 6, 2);
        pulse_load(0);
        check("load on wrap ack", load_ack[0], 1);
        measure(0, lo, hi);
        check("div6 low", lo, 4);
        check("div6 high", hi, 2);

        // Second channel on a different shape, then double load on ch0.
        set_cfg(1, 5, 2);
        ch_en[1] = 1'b0;
        pulse_load(1);
        check("ch1 idle load ack", load_ack[1], 1);
        ch_en[1] = 1'b1;
        wait_edge(0, 1'b0, n);
        set_cfg(0, 8, 4);
        pulse_load(0);
        set_cfg(0, 6, 3);
        pulse_load(0);
        acks       = 0;
        other_acks = 0;
        repeat (20) begin
            tick();
            acks       += int'(load_ack[0]);
            other_acks += int'(load_ack[1]);
        end
        check("double load acks", acks, 1);
        check("no cross-channel ack", other_acks, 0);
        measure(0, lo, hi);
        check("replaced shadow low", lo, 3);
        check("replaced shadow high", hi, 3);
        measure(1, lo, hi);
        check("ch1 low", lo, 3);
        check("ch1 high", hi, 2);

        foreach (tbl[i]) begin
            set_cfg(tbl[i].ch, tbl[i].div, tbl[i].hi);
            ch_en[tbl[i].ch] = 1'b0;
            pulse_load(tbl[i].ch);
            check($sformatf("vec%0d idle ack", i), load_ack[tbl[i].ch], 1);
            ch_en[tbl[i].ch] = 1'b1;
            if (tbl[i].mode == 0) begin
                measure(tbl[i].ch, lo, hi);
                check($sformatf("vec%0d low", i), lo, tbl[i].exp_lo);
                check($sformatf("vec%0d high", i), hi, tbl[i].exp_hi);
            end else begin
                repeat (3) tick();
                nticks = 0;
                nbad   = 0;
                repeat (30) begin
                    tick();
                    nticks += int'(rise_tick[tbl[i].ch]) + int'(fall_tick[tbl[i].ch]);
                    if (clk_out[tbl[i].ch] !== (tbl[i].mode == 2)) nbad++;
                end
                check($sformatf("vec%0d ticks", i), nticks, 0);
                check($sformatf("vec%0d stuck level", i), nbad, 0);
            end
        end

        // Reset mid-period at cnt=123 with a load pending.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ch_en = '1;
        set_cfg(0, 10, 3);
        pulse_load(0);
        repeat (122) tick();
        rst = 1'b1;
        tick();
        check("rst abort clk_out", clk_out[0], 0);
        check("rst abort ticks", {rise_tick[0], fall_tick[0]}, 0);
        check("rst abort load_ack", load_ack[0], 0);
        rst  = 1'b0;
        acks = 0;
        n    = 0;
        do begin
            tick();
            n++;
            acks += int'(load_ack[0]);
        end while (!rise_tick[0] && n < LIMIT);
        check("post-rst first rise", n, 250);
        check("post-rst no ack", acks, 0);
        measure(0, lo, hi);
        check("post-rst high", hi, 250);
        check("post-rst low", lo, 250);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_divider_multi.md
CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent divider channels, 1..8.
REQ-002 Parameter CNT_W, default 27: counter and divisor width in bits.
REQ-003 Parameter DEF_DIV, default 500: divisor loaded at reset; default high count is DEF_DIV/2 (floor).
REQ-004 Port clk_in  input  1: single clock; all logic on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port ch_en  input  NUM_CH: per-channel run enable.
REQ-007 Port div_val  input  NUM_CH*CNT_W: requested divisor per channel; channel i occupies bits [i*CNT_W +: CNT_W].
REQ-008 Port hi_cnt  input  NUM_CH*CNT_W: requested high-phase length per channel, packed like div_val.
REQ-009 Port load  input  NUM_CH: one-cycle strobe; captures that channel's div_val/hi_cnt into its shadow register.
REQ-010 Port load_ack  output  NUM_CH: one-cycle pulse when shadow values become active.
REQ-011 Port clk_out  output  NUM_CH: registered divided clock per channel.
REQ-012 Port rise_tick  output  NUM_CH: one-cycle pulse in the cycle clk_out goes 0->1.
REQ-013 Port fall_tick  output  NUM_CH: one-cycle pulse in the cycle clk_out goes 1->0.

Function
REQ-014 Each channel SHALL hold a counter cnt that counts 0..act_div-1 and wraps to 0, advancing once per clk_in while ch_en=1.
REQ-015 clk_out SHALL be registered: next clk_out = 0 if cnt < act_div-act_hi, else 1; period is exactly act_div clk_in cycles.
REQ-016 Effective divisor SHALL be max(div_val,2); hi_cnt=0 SHALL give constant 0; hi_cnt >= effective divisor SHALL give constant 1 (no ticks).
REQ-017 load SHALL overwrite the shadow and set a pending flag; a second load before apply SHALL replace the shadow, with a single load_ack.
REQ-018 Pending values SHALL be applied only at the wrap cycle (cnt=act_div-1) or immediately while ch_en=0; the counter restarts at 0 with the new values and load_ack pulses in that cycle.
REQ-019 load coincident with the wrap cycle SHALL apply in that same cycle.
REQ-020 ch_en deassert: cnt <= 0, clk_out <= 0 on the next edge; a fall_tick is emitted if clk_out was 1.
REQ-021 ch_en assert: counting starts from cnt=0; the first clk_out rise occurs act_div-act_hi cycles later.
REQ-022 rise_tick/fall_tick SHALL be registered and aligned with the clk_out edge they mark; never both asserted together.
REQ-023 Channels SHALL be fully independent; no cross-channel timing dependence.

Reset
REQ-024 On rst: cnt=0, clk_out=0, rise_tick=0, fall_tick=0, load_ack=0, pending=0, act_div=DEF_DIV, act_hi=DEF_DIV/2, shadow=active values.
REQ-025 rst asserted mid-period SHALL abort the period and discard any pending load without load_ack.

Structure
REQ-026 A shared package SHALL hold CNT_W default, DEF_DIV default and the clamp constant MIN_DIV=2.
REQ-027 One sub-module clock_divider_chan SHALL implement a single channel; the top level SHALL be a generate loop plus port packing only.

Verification
REQ-028 Reset defaults, ch_en=1, DEF_DIV=500 -> clk_out low for 250 cycles, high for 250; rise_tick every 500 cycles.
REQ-029 ch0 div=10, hi=3, load mid-period -> old period completes; load_ack at wrap; then 7 low / 3 high repeating.
REQ-030 div_val=1 -> clamped to 2 (1 low / 1 high); hi_cnt=0 -> clk_out stuck 0, no ticks; hi_cnt=12 with div=10 -> stuck 1.
REQ-031 ch_en dropped while clk_out=1 -> next cycle clk_out=0, one fall_tick; re-enable -> rise after div-hi cycles.
REQ-032 Two loads (div=8, then div=6) before wrap -> single load_ack, period 6; other channel's period unchanged.
REQ-033 rst pulsed at cnt=123 with pending load -> outputs 0, no load_ack, divisor back to 500.
